// File: rtl/auto_song_fetch_pkg.sv
// Shared constants, state encoding and duration helper for the song fetch block.
package auto_song_fetch_pkg;

   localparam int unsigned NOTE_W  = 4;
   localparam int unsigned CODE_W  = 3;
   localparam int unsigned ENTRY_W = NOTE_W + CODE_W;
   localparam int unsigned ADDR_W  = 5;
   localparam int unsigned SONG_W  = 2;
   localparam int unsigned DUR_W   = 26;

   localparam logic [NOTE_W-1:0] END_NOTE  = 4'hF;
   localparam logic [NOTE_W-1:0] REST_NOTE = 4'h0;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StPlay,
      StDone
   } fetch_state_e;

   // Ticks for a duration code, saturated to the duration width.
   function automatic logic [DUR_W-1:0] dur_ticks(input int unsigned base,
                                                  input logic [CODE_W-1:0] code);
      logic [63:0] prod;
      prod = 64'(base) * (64'(code) + 64'd1);
      if (prod > 64'(2 ** DUR_W - 1)) begin
         return '1;
      end
      return prod[DUR_W-1:0];
   endfunction

endpackage

// File: rtl/auto_song_fetch_if.sv
// Handshake/bus signals between the song fetch block and its user.
interface auto_song_fetch_if;
   import auto_song_fetch_pkg::*;

   logic [SONG_W-1:0] song_select;
   logic              song_load;
   logic [ADDR_W-1:0] nxt_auto_memory_location;
   logic [NOTE_W-1:0] note_value;
   logic [DUR_W-1:0]  duration_value;
   logic              fetch_valid;
   logic              song_end;
   logic [SONG_W-1:0] current_song;

   modport master (
      output song_select, song_load, nxt_auto_memory_location,
      input  note_value, duration_value, fetch_valid, song_end, current_song
   );

   modport slave (
      input  song_select, song_load, nxt_auto_memory_location,
      output note_value, duration_value, fetch_valid, song_end, current_song
   );

endinterface

// File: rtl/auto_song_fetch_song_rom.sv
// Combinational song table: 4 songs x 32 entries of {note, duration code}.
module song_rom
   import auto_song_fetch_pkg::*;
(
   input  logic [SONG_W-1:0] song,
   input  logic [ADDR_W-1:0] addr,
   output logic [NOTE_W-1:0] note,
   output logic [CODE_W-1:0] dur_code
);

   // Song 3 carries no end marker so it loops forever.
   always_comb begin
      note     = END_NOTE;
      dur_code = '0;
      unique case (song)
         2'd0: begin
            unique case (addr)
               5'd0:    begin note = 4'd1; dur_code = 3'd0; end
               5'd1:    begin note = 4'd3; dur_code = 3'd7; end
               5'd2:    begin note = 4'd5; dur_code = 3'd1; end
               5'd3:    begin note = REST_NOTE; dur_code = 3'd2; end
               5'd4:    begin note = 4'd8; dur_code = 3'd3; end
               default: begin note = END_NOTE; dur_code = '0; end
            endcase
         end
         2'd1: begin
            unique case (addr)
               5'd0:    begin note = 4'd10; dur_code = 3'd2; end
               5'd1:    begin note = 4'd12; dur_code = 3'd7; end
               5'd2:    begin note = 4'd14; dur_code = 3'd4; end
               default: begin note = END_NOTE; dur_code = '0; end
            endcase
         end
         2'd2: begin
            unique case (addr)
               5'd0:    begin note = 4'd2; dur_code = 3'd5; end
               5'd1:    begin note = 4'd4; dur_code = 3'd6; end
               default: begin note = END_NOTE; dur_code = '0; end
            endcase
         end
         default: begin
            note     = {1'b0, addr[2:0]} + 4'd1;
            dur_code = ~addr[2:0];
         end
      endcase
   end

endmodule

// File: rtl/auto_song_fetch.sv
// Song fetch sequencer: loads a song and serves registered entries to the auto player.
module auto_song_fetch
   import auto_song_fetch_pkg::*;
#(
   parameter int unsigned BASE_TICKS = 6_250_000,
   parameter int unsigned SONG_COUNT = 4
) (
   input logic               clk,
   input logic               rst,
   auto_song_fetch_if.slave  bus
);

   localparam logic [DUR_W-1:0] DUR_TABLE [8] = '{
      dur_ticks(BASE_TICKS, 3'd0), dur_ticks(BASE_TICKS, 3'd1),
      dur_ticks(BASE_TICKS, 3'd2), dur_ticks(BASE_TICKS, 3'd3),
      dur_ticks(BASE_TICKS, 3'd4), dur_ticks(BASE_TICKS, 3'd5),
      dur_ticks(BASE_TICKS, 3'd6), dur_ticks(BASE_TICKS, 3'd7)
   };

   fetch_state_e      state_q, state_d;
   logic [SONG_W-1:0] song_q, song_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [NOTE_W-1:0] note_q, note_d;
   logic [DUR_W-1:0]  dur_q, dur_d;
   logic              valid_q, valid_d;
   logic              end_q, end_d;
   logic              pend_q, pend_d;  // address captured, entry read due next cycle
   logic              rd_en;

   logic [ADDR_W-1:0] rd_addr;
   logic [NOTE_W-1:0] rom_note;
   logic [CODE_W-1:0] rom_code;

   // LOAD always reads entry 0; otherwise read the last captured address.
   assign rd_addr = (state_q == StLoad) ? '0 : addr_q;

   song_rom u_song_rom (
      .song     (song_q),
      .addr     (rd_addr),
      .note     (rom_note),
      .dur_code (rom_code)
   );

   // Next-state and output-register update.
   always_comb begin
      state_d = state_q;
      song_d  = song_q;
      addr_d  = addr_q;
      note_d  = note_q;
      dur_d   = dur_q;
      valid_d = valid_q;
      end_d   = end_q;
      pend_d  = pend_q;
      rd_en   = 1'b0;

      if (bus.song_load) begin
         // Load wins over any address change or pending fetch.
         state_d = StLoad;
         song_d  = ({30'd0, bus.song_select} < SONG_COUNT) ? bus.song_select : '0;
         valid_d = 1'b0;
         end_d   = 1'b0;
         pend_d  = 1'b0;
      end else begin
         unique case (state_q)
            StLoad: begin
               addr_d = '0;
               rd_en  = 1'b1;
            end
            StPlay: begin
               if (bus.nxt_auto_memory_location != addr_q) begin
                  addr_d  = bus.nxt_auto_memory_location;
                  valid_d = 1'b0;
                  pend_d  = 1'b1;
               end else if (pend_q) begin
                  pend_d = 1'b0;
                  rd_en  = 1'b1;
               end
            end
            default: ;
         endcase
      end

      if (rd_en) begin
         if (rom_note == END_NOTE) begin
            state_d = StDone;
            note_d  = REST_NOTE;
            dur_d   = '0;
            valid_d = 1'b0;
            end_d   = 1'b1;
         end else begin
            state_d = StPlay;
            note_d  = rom_note;
            dur_d   = DUR_TABLE[rom_code];
            valid_d = 1'b1;
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         song_q  <= '0;
         addr_q  <= '0;
         note_q  <= REST_NOTE;
         dur_q   <= '0;
         valid_q <= 1'b0;
         end_q   <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         song_q  <= song_d;
         addr_q  <= addr_d;
         note_q  <= note_d;
         dur_q   <= dur_d;
         valid_q <= valid_d;
         end_q   <= end_d;
         pend_q  <= pend_d;
      end
   end

   assign bus.note_value     = note_q;
   assign bus.duration_value = dur_q;
   assign bus.fetch_valid    = valid_q;
   assign bus.song_end       = end_q;
   assign bus.current_song   = song_q;

endmodule

// File: tb/tb_auto_song_fetch.sv
// Directed bench for auto_song_fetch with hand-computed expected outputs.
module tb_auto_song_fetch;
   import auto_song_fetch_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   auto_song_fetch_if bus ();

   auto_song_fetch dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Observed output bundle: {note, duration, fetch_valid, song_end, current_song}.
   logic [33:0] obs;
   logic [33:0] exp;
   always_comb obs = {bus.note_value, bus.duration_value, bus.fetch_valid, bus.song_end,
                      bus.current_song};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.song_load = 1'b0;
      bus.song_select = 2'd0;
      bus.nxt_auto_memory_location = 5'd0;
      step();
      step();
      exp = {4'd0, 26'd0, 1'b0, 1'b0, 2'd0};
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL reset_outputs: got %h expected %h", obs, exp);
      end
      n_checks++;
      if (dut.state_q !== StIdle) begin
         n_errors++;
         $display("FAIL reset_state: got %0d expected %0d", dut.state_q, StIdle);
      end
   endtask

   task automatic test_load();
      rst = 1'b0;
      bus.song_select = 2'd1;
      bus.song_load = 1'b1;
      step();
      bus.song_load = 1'b0;
      n_checks++;
      if (dut.state_q !== StLoad || bus.fetch_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL load_state: got state %0d valid %b expected state %0d valid 0",
                  dut.state_q, bus.fetch_valid, StLoad);
      end
      step();
      exp = {4'd10, 26'd18_750_000, 1'b1, 1'b0, 2'd1};
      n_checks++;
      if (obs !== exp || dut.state_q !== StPlay) begin
         n_errors++;
         $display("FAIL load_entry0: got %h state %0d expected %h state %0d",
                  obs, dut.state_q, exp, StPlay);
      end
   endtask

   task automatic test_addr_change();
      bus.nxt_auto_memory_location = 5'd1;
      step();
      n_checks++;
      if (bus.fetch_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL addr_valid_drop: got %b expected 0", bus.fetch_valid);
      end
      step();
      exp = {4'd12, 26'd50_000_000, 1'b1, 1'b0, 2'd1};
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL addr_entry1: got %h expected %h", obs, exp);
      end
      step();
      step();
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL addr_stable: got %h expected %h", obs, exp);
      end
   endtask

   task automatic test_song_end();
      logic [3:0] nt [4] = '{4'd3, 4'd5, 4'd0, 4'd8};
      logic [25:0] dt [4] = '{26'd50_000_000, 26'd12_500_000, 26'd18_750_000, 26'd25_000_000};
      bus.song_select = 2'd0;
      bus.song_load = 1'b1;
      bus.nxt_auto_memory_location = 5'd0;
      step();
      bus.song_load = 1'b0;
      step();
      exp = {4'd1, 26'd6_250_000, 1'b1, 1'b0, 2'd0};
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL song0_entry0: got %h expected %h", obs, exp);
      end
      for (int i = 0; i < 4; i++) begin
         bus.nxt_auto_memory_location = 5'(i + 1);
         step();
         n_checks++;
         if (bus.fetch_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL song0_drop%0d: got %b expected 0", i + 1, bus.fetch_valid);
         end
         step();
         exp = {nt[i], dt[i], 1'b1, 1'b0, 2'd0};
         n_checks++;
         if (obs !== exp) begin
            n_errors++;
            $display("FAIL song0_entry%0d: got %h expected %h", i + 1, obs, exp);
         end
      end
      bus.nxt_auto_memory_location = 5'd5;
      step();
      step();
      exp = {4'd0, 26'd0, 1'b0, 1'b1, 2'd0};
      n_checks++;
      if (obs !== exp || dut.state_q !== StDone) begin
         n_errors++;
         $display("FAIL song0_done: got %h state %0d expected %h state %0d",
                  obs, dut.state_q, exp, StDone);
      end
      bus.nxt_auto_memory_location = 5'd9;
      step();
      step();
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL done_hold: got %h expected %h", obs, exp);
      end
   endtask

   task automatic test_load_priority();
      bus.song_select = 2'd2;
      bus.song_load = 1'b1;
      bus.nxt_auto_memory_location = 5'd0;
      step();
      bus.song_load = 1'b0;
      step();
      exp = {4'd2, 26'd37_500_000, 1'b1, 1'b0, 2'd2};
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL song2_entry0: got %h expected %h", obs, exp);
      end
      bus.nxt_auto_memory_location = 5'd1;
      bus.song_select = 2'd1;
      bus.song_load = 1'b1;
      step();
      n_checks++;
      if (dut.state_q !== StLoad || bus.fetch_valid !== 1'b0 || bus.current_song !== 2'd1) begin
         n_errors++;
         $display("FAIL prio_load: got state %0d valid %b song %0d expected state %0d valid 0 song 1",
                  dut.state_q, bus.fetch_valid, bus.current_song, StLoad);
      end
      bus.song_load = 1'b0;
      bus.nxt_auto_memory_location = 5'd0;
      step();
      exp = {4'd10, 26'd18_750_000, 1'b1, 1'b0, 2'd1};
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL prio_entry0: got %h expected %h", obs, exp);
      end
      step();
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL prio_hold: got %h expected %h", obs, exp);
      end
   endtask

   task automatic test_load_restart();
      bus.song_select = 2'd2;
      bus.song_load = 1'b1;
      step();
      bus.song_select = 2'd0;
      step();
      n_checks++;
      if (dut.state_q !== StLoad || bus.current_song !== 2'd0) begin
         n_errors++;
         $display("FAIL restart_load: got state %0d song %0d expected state %0d song 0",
                  dut.state_q, bus.current_song, StLoad);
      end
      bus.song_load = 1'b0;
      step();
      exp = {4'd1, 26'd6_250_000, 1'b1, 1'b0, 2'd0};
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL restart_entry0: got %h expected %h", obs, exp);
      end
   endtask

   task automatic test_reset_midplay();
      bus.nxt_auto_memory_location = 5'd1;
      step();
      n_checks++;
      if (bus.fetch_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL midplay_drop: got %b expected 0", bus.fetch_valid);
      end
      rst = 1'b1;
      step();
      exp = {4'd0, 26'd0, 1'b0, 1'b0, 2'd0};
      n_checks++;
      if (obs !== exp || dut.state_q !== StIdle) begin
         n_errors++;
         $display("FAIL midplay_reset: got %h state %0d expected %h state %0d",
                  obs, dut.state_q, exp, StIdle);
      end
      rst = 1'b0;
      bus.nxt_auto_memory_location = 5'd2;
      step();
      step();
      n_checks++;
      if (obs !== exp || dut.state_q !== StIdle) begin
         n_errors++;
         $display("FAIL idle_ignore_addr: got %h state %0d expected %h state %0d",
                  obs, dut.state_q, exp, StIdle);
      end
   endtask

   task automatic test_wrap();
      bus.song_select = 2'd3;
      bus.song_load = 1'b1;
      bus.nxt_auto_memory_location = 5'd0;
      step();
      bus.song_load = 1'b0;
      step();
      exp = {4'd1, 26'd50_000_000, 1'b1, 1'b0, 2'd3};
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL song3_entry0: got %h expected %h", obs, exp);
      end
      bus.nxt_auto_memory_location = 5'd31;
      step();
      step();
      exp = {4'd8, 26'd6_250_000, 1'b1, 1'b0, 2'd3};
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL song3_entry31: got %h expected %h", obs, exp);
      end
      bus.nxt_auto_memory_location = 5'd0;
      step();
      n_checks++;
      if (bus.fetch_valid !== 1'b0 || bus.song_end !== 1'b0) begin
         n_errors++;
         $display("FAIL wrap_drop: got valid %b end %b expected valid 0 end 0",
                  bus.fetch_valid, bus.song_end);
      end
      step();
      exp = {4'd1, 26'd50_000_000, 1'b1, 1'b0, 2'd3};
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL wrap_entry0: got %h expected %h", obs, exp);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_addr_change();
      test_song_end();
      test_load_priority();
      test_load_restart();
      test_reset_midplay();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/auto_song_fetch.md
AUTO_SONG_FETCH -- requirements
Module: auto_song_fetch

Interface
REQ-001 Parameter BASE_TICKS, default 6_250_000, clock cycles per duration unit (62.5 ms at 100 MHz).
REQ-002 Parameter SONG_COUNT, default 4, number of stored songs (max 4).
REQ-003 The clock SHALL be `clk`, input, 1 bit, the single system clock.
REQ-004 The reset SHALL be `rst`, input, 1 bit, synchronous and active-high.
REQ-005 Port `song_select`, input, 2 bits, song index sampled on load.
REQ-006 Port `song_load`, input, 1 bit, single-cycle pulse that starts the selected song.
REQ-007 Port `nxt_auto_memory_location`, input, 5 bits, entry address requested by the downstream auto player.
REQ-008 Port `note_value`, output, 4 bits, registered note: 0 is rest, 1..14 are tones, 15 is never driven.
REQ-009 Port `duration_value`, output, 26 bits, registered note length in clock cycles.
REQ-010 Port `fetch_valid`, output, 1 bit, high while note_value and duration_value belong to the current address.
REQ-011 Port `song_end`, output, 1 bit, high in DONE.
REQ-012 Port `current_song`, output, 2 bits, latched song index.

Function
REQ-013 Song storage SHALL be 4 songs x 32 entries; each entry is a 4-bit note plus a 3-bit duration code.
REQ-014 Note code 4'hF SHALL be the end marker.
REQ-015 duration_value SHALL equal BASE_TICKS*(code+1), saturated to 26'h3FFFFFF.
REQ-016 The FSM SHALL have states IDLE, LOAD, PLAY and DONE.
- IDLE: outputs rest, fetch_valid=0.
- song_load in any state: latch song_select into current_song (a value >= SONG_COUNT maps to 0) -> LOAD.
- LOAD (1 cycle): read entry 0 -> PLAY.
- PLAY: on each cycle where nxt_auto_memory_location differs from the last fetched address, drop fetch_valid for 1 cycle, read the new entry, and raise fetch_valid on the next cycle.
  - Read latency is exactly 1 cycle from an address change to the output update.
- Entry read returns end marker -> DONE.
  - In DONE: note_value=0, duration_value=0, song_end=1, fetch_valid=0.
- DONE: hold until song_load or rst.
REQ-017 An unchanged address in PLAY SHALL leave the outputs stable with no re-read.
REQ-018 An address wrap from 31 to 0 in PLAY SHALL be treated as an ordinary change: entry 0 is re-read and the song loops.
REQ-019 A song with no end marker in 32 entries SHALL loop indefinitely.
REQ-020 song_load coinciding with an address change SHALL take priority: the address change is ignored and the block goes to LOAD.
REQ-021 song_load in LOAD SHALL restart LOAD with the new song_select.
REQ-022 Address changes in IDLE, LOAD and DONE SHALL be ignored.

Reset
REQ-023 rst=1 at a clock edge SHALL set the following, overriding song_load and any fetch in flight:
- state=IDLE
- note_value=0
- duration_value=0
- fetch_valid=0
- song_end=0
- current_song=0
- last fetched address=0
REQ-024 Reset SHALL be synchronous only; there is no asynchronous path.

Structure
REQ-025 A shared package SHALL hold:
- END_NOTE=4'hF
- REST_NOTE=4'h0
- FSM state encoding
- entry width 7
- the address and duration widths
REQ-026 Song contents SHALL live in a single sub-module, song_rom.
- Interface: input song[1:0] and addr[4:0]; output note[3:0] and dur_code[2:0].
- Purely combinational; the registered stage sits in auto_song_fetch.
REQ-027 Duration multiply SHALL be done combinationally on the 3-bit code (constant table of 8 values); no runtime multiplier is permitted.

Verification
REQ-028 Reset then song_load with song_select=1 -> LOAD for 1 cycle, then PLAY; the next cycle drives the song-1 entry 0 with fetch_valid=1 and current_song=1.
REQ-029 In PLAY, change the address 0->1 at cycle N -> fetch_valid=0 at N+1 and the entry-1 values with fetch_valid=1 at N+2; duration code 7 -> duration_value=50_000_000.
REQ-030 Step addresses until the end marker (song 0, entry k) -> song_end=1, note_value=0, duration_value=0; further address changes leave the outputs unchanged.
REQ-031 song_load in the same cycle as an address change in PLAY -> LOAD entered, entry 0 of the new song output, the address change discarded.
REQ-032 rst asserted mid-PLAY, one cycle after an address change -> all outputs at reset values on the next edge and the state is IDLE.
REQ-033 Song with no end marker, address stepped 31->0 -> entry 0 re-read with 1-cycle latency and song_end stays 0.
